// File: rtl/n_acc_feeder_pkg.sv
// Shared constants and FSM encoding for the adder-array accumulate feeder.
package n_acc_feeder_pkg;

    localparam int unsigned D_LEN_DFLT  = 32;
    localparam int unsigned CELL_N_DFLT = 8;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_ARM    = 3'd1,
        ST_ACK    = 3'd2,
        ST_RUN    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_OUT    = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/n_lane_packer.sv
// Serial-to-lane buffer: writes words into successive lanes, zero-pads the tail
// on the flushing word and latches whether that flush closed a dot product.
module n_lane_packer
    import n_acc_feeder_pkg::*;
#(
    parameter int unsigned CELL_N = CELL_N_DFLT,
    parameter int unsigned D_LEN  = D_LEN_DFLT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [D_LEN-1:0]        wr_data,
    input  logic                    wr_last,
    output logic [CELL_N*D_LEN-1:0] lanes,
    output logic                    last_flag,
    output logic                    done_c
);

    localparam int unsigned CNT_W = (CELL_N > 1) ? $clog2(CELL_N) : 1;

    logic [CNT_W-1:0] cnt;

    // A full vector and in_last on the same word collapse into a single flush.
    assign done_c = wr_en && (wr_last || (cnt == CNT_W'(CELL_N - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes     <= '0;
            cnt       <= '0;
            last_flag <= 1'b0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < CELL_N; k++) begin
                if (CNT_W'(k) == cnt) begin
                    lanes[k*D_LEN +: D_LEN] <= wr_data;
                end else if (done_c && (CNT_W'(k) > cnt)) begin
                    lanes[k*D_LEN +: D_LEN] <= D_LEN'(FP_ZERO);
                end
            end
            cnt <= done_c ? '0 : cnt + CNT_W'(1);
            if (done_c) begin
                last_flag <= wr_last;
            end
        end
    end

endmodule

// File: rtl/n_acc_feeder.sv
// Initiator side of the adder-array accumulate interface: packs products into a
// lane vector, runs the acc_start/acc_finish handshake and returns each lane sum.
module n_acc_feeder
    import n_acc_feeder_pkg::*;
#(
    parameter int unsigned CELL_N = CELL_N_DFLT,
    parameter int unsigned D_LEN  = D_LEN_DFLT,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned TMO_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [D_LEN-1:0]        in_data,
    input  logic                    in_last,
    output logic [CELL_N*D_LEN-1:0] mult_out,
    output logic                    mult_wen,
    output logic                    acc_start,
    input  logic                    acc_finish,
    input  logic [D_LEN-1:0]        acc_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [D_LEN-1:0]        res_data,
    output logic                    res_last,
    output logic [IDX_W-1:0]        res_idx,
    output logic                    err_tmo
);

    feeder_state_e    state_q, state_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic [IDX_W-1:0] chunk_q, chunk_d;
    logic             accept_c, done_c, last_flag, watch_c, tmo_c;
    logic             in_ready_d, acc_start_d, mult_wen_d, res_valid_d, res_last_d, err_tmo_d;
    logic [D_LEN-1:0] res_data_d;
    logic [IDX_W-1:0] res_idx_d;

    assign accept_c = in_valid && in_ready;
    assign watch_c  = (state_q == ST_ACK) || (state_q == ST_RUN);
    assign tmo_c    = watch_c && (wd_q == '1);

    n_lane_packer #(
        .CELL_N (CELL_N),
        .D_LEN  (D_LEN)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept_c),
        .wr_data   (in_data),
        .wr_last   (in_last),
        .lanes     (mult_out),
        .last_flag (last_flag),
        .done_c    (done_c)
    );

    // State, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            wd_q      <= '0;
            chunk_q   <= '0;
            in_ready  <= 1'b0;
            acc_start <= 1'b0;
            mult_wen  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
            res_idx   <= '0;
            err_tmo   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            chunk_q   <= chunk_d;
            in_ready  <= in_ready_d;
            acc_start <= acc_start_d;
            mult_wen  <= mult_wen_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_last  <= res_last_d;
            res_idx   <= res_idx_d;
            err_tmo   <= err_tmo_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        in_ready_d  = in_ready;
        acc_start_d = acc_start;
        mult_wen_d  = mult_wen;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_last_d  = res_last;
        res_idx_d   = res_idx;
        err_tmo_d   = err_tmo;

        case (state_q)
            ST_FILL: begin
                in_ready_d = 1'b1;
                if (done_c) begin
                    in_ready_d = 1'b0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (acc_finish) begin
                    acc_start_d = 1'b1;
                    mult_wen_d  = 1'b1;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!acc_finish) begin
                    acc_start_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_finish) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                res_data_d  = acc_out;
                res_last_d  = last_flag;
                res_idx_d   = chunk_q;
                mult_wen_d  = 1'b0;
                res_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_valid && res_ready) begin
                    res_valid_d = 1'b0;
                    chunk_d     = last_flag ? '0 : chunk_q + IDX_W'(1);
                    in_ready_d  = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Watchdog expiry abandons the vector and overrides the handshake.
        if (tmo_c) begin
            err_tmo_d   = 1'b1;
            acc_start_d = 1'b0;
            mult_wen_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_FILL;
        end
    end

    // Watchdog restarts on every state change and only counts in ACK/RUN.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (watch_c) begin
            wd_d = wd_q + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_n_acc_feeder.sv
// Bench for n_acc_feeder: behavioural adder-array model plus a result scoreboard.
module tb_n_acc_feeder;

    localparam int unsigned CELL_N = 8;
    localparam int unsigned D_LEN  = 32;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned TMO_W  = 10;
    localparam int unsigned DW     = CELL_N * D_LEN;

    logic              clk, rst_n;
    logic              in_valid, in_ready, in_last;
    logic [D_LEN-1:0]  in_data;
    logic [DW-1:0]     mult_out;
    logic              mult_wen, acc_start, acc_finish;
    logic [D_LEN-1:0]  acc_out;
    logic              res_valid, res_ready, res_last, err_tmo;
    logic [D_LEN-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;

    n_acc_feeder #(
        .CELL_N (CELL_N), .D_LEN (D_LEN), .IDX_W (IDX_W), .TMO_W (TMO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mult_out   (mult_out),
        .mult_wen   (mult_wen),
        .acc_start  (acc_start),
        .acc_finish (acc_finish),
        .acc_out    (acc_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_last   (res_last),
        .res_idx    (res_idx),
        .err_tmo    (err_tmo)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [7:0]  idx;
    } exp_t;

    typedef struct {
        int              n;
        logic [31:0]     w;
        logic [2:0][31:0] e;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t m;
    vec_t tbl[6];

    logic [DW-1:0] cap_vec;
    logic [31:0]   sum_bits;
    logic          adder_hang;
    int            busy_cnt;
    real           acc_sum;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) d = {f[31], 63'h0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Adder array: samples on negedge, drops finish while busy, sum appears as finish rises.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_finish <= 1'b1;
            acc_out    <= '0;
            busy_cnt   = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                acc_out    <= sum_bits;
                acc_finish <= 1'b1;
            end
        end else if (acc_start && mult_wen && acc_finish && !adder_hang) begin
            cap_vec = mult_out;
            acc_sum = 0.0;
            for (int k = 0; k < CELL_N; k++) acc_sum += f2r(cap_vec[k*D_LEN +: D_LEN]);
            sum_bits   = r2f(acc_sum);
            acc_finish <= 1'b0;
            busy_cnt   = 4;
        end
    end

    // Scoreboard: every accepted result is compared against the next expected one.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %h want none", res_data);
            end else begin
                m = sb.pop_front();
                chk("res_data", res_data, m.data);
                chk("res_last", 32'(res_last), 32'(m.last));
                chk("res_idx", 32'(res_idx), 32'(m.idx));
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int   b;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        b = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            b++;
        end while (!acc && b < 2000);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vec(input int n, input logic [31:0] w, input logic [2:0][31:0] e,
                            input bit push);
        int   nch;
        exp_t x;
        nch = (n + CELL_N - 1) / CELL_N;
        if (push) begin
            for (int c = 0; c < nch; c++) begin
                x.data = e[c];
                x.last = (c == nch - 1);
                x.idx  = 8'(c);
                sb.push_back(x);
            end
        end
        for (int i = 0; i < n; i++) send_word(w, i == n - 1);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((sb.size() != 0 || res_valid) && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b >= 3000) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_vec(input int i, input int n, input logic [31:0] w,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        tbl[i].n = n;
        tbl[i].w = w;
        tbl[i].e = {e2, e1, e0};
    endtask

    initial begin
        int          b;
        int          t0;
        logic        ok;
        logic [31:0] ref_d;
        logic [31:0] lane;
        logic [2:0][31:0] no_exp;

        set_vec(0,  8, 32'h3F80_0000, 32'h4100_0000, 32'h0,         32'h0);
        set_vec(1,  3, 32'h4000_0000, 32'h40C0_0000, 32'h0,         32'h0);
        set_vec(2, 20, 32'h3F80_0000, 32'h4100_0000, 32'h4100_0000, 32'h4080_0000);
        set_vec(3,  1, 32'h4040_0000, 32'h4040_0000, 32'h0,         32'h0);
        set_vec(4, 16, 32'h4000_0000, 32'h4180_0000, 32'h4180_0000, 32'h0);
        set_vec(5,  9, 32'h3F80_0000, 32'h4100_0000, 32'h3F80_0000, 32'h0);
        no_exp = '0;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        res_ready  = 1'b1;
        adder_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_acc_start", 32'(acc_start), 32'd0);
        chk("rst_mult_wen", 32'(mult_wen), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err_tmo", 32'(err_tmo), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_mult_out_nz", 32'(mult_out != '0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("fill_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send_vec(tbl[i].n, tbl[i].w, tbl[i].e, 1'b1);
            wait_drain();
            if (i == 1) begin
                for (int k = 0; k < CELL_N; k++) begin
                    lane = cap_vec[k*D_LEN +: D_LEN];
                    chk($sformatf("pad_lane%0d", k), lane, (k < 3) ? 32'h4000_0000 : 32'h0);
                end
            end
        end

        // Result held in OUT while downstream stalls; no input taken meanwhile.
        res_ready = 1'b0;
        send_vec(8, 32'h3F80_0000, {32'h0, 32'h0, 32'h4100_0000}, 1'b1);
        b = 0;
        while (!res_valid && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("stall_reach_out", 32'(res_valid), 32'd1);
        ref_d    = res_data;
        ok       = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        repeat (50) begin
            @(negedge clk);
            if (!res_valid || res_data !== ref_d || in_ready) ok = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("stall_stable", 32'(ok), 32'd1);
        chk("stall_data", ref_d, 32'h4100_0000);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_drain();

        // Adder never acknowledges: watchdog fires and the result is dropped.
        adder_hang = 1'b1;
        send_vec(8, 32'h3F80_0000, no_exp, 1'b0);
        b = 0;
        while (!acc_start && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("tmo_start_seen", 32'(acc_start), 32'd1);
        t0 = cyc;
        b  = 0;
        while (!err_tmo && b < 1500) begin
            @(negedge clk);
            b++;
        end
        chk("tmo_flag", 32'(err_tmo), 32'd1);
        chk("tmo_window", 32'((cyc - t0 >= 1023) && (cyc - t0 <= 1025)), 32'd1);
        @(posedge clk);
        #1;
        chk("tmo_acc_start", 32'(acc_start), 32'd0);
        chk("tmo_mult_wen", 32'(mult_wen), 32'd0);
        chk("tmo_res_valid", 32'(res_valid), 32'd0);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);
        chk("tmo_sticky", 32'(err_tmo), 32'd1);
        adder_hang = 1'b0;

        // Reset while the adder is busy, then a clean vector.
        send_vec(8, 32'h4000_0000, no_exp, 1'b0);
        b = 0;
        while (!(mult_wen && !acc_start && !acc_finish) && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("run_reached", 32'(mult_wen && !acc_start && !acc_finish), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mult_wen", 32'(mult_wen), 32'd0);
        chk("mid_rst_acc_start", 32'(acc_start), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_err_tmo", 32'(err_tmo), 32'd0);
        chk("mid_rst_mult_out_nz", 32'(mult_out != '0), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_vec(8, 32'h3F80_0000, {32'h0, 32'h0, 32'h4100_0000}, 1'b1);
        wait_drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
